// File: rtl/exec_writeback_unit_if.sv
// Bundle of signals between the execute/writeback unit, its instruction
// source and the 4-entry register file. The unit is the slave side; the
// environment (instruction issuer + register file) is the master side.
interface exec_writeback_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [2:0]            instr_opcode;
    logic [IDX_WIDTH-1:0]  instr_dst;
    logic [IDX_WIDTH-1:0]  instr_src;
    logic [DATA_WIDTH-1:0] instr_imm;
    logic [IDX_WIDTH-1:0]  rf_read_index;
    logic [DATA_WIDTH-1:0] rf_read_data;
    logic [IDX_WIDTH-1:0]  rf_write_index;
    logic                  rf_write_enable;
    logic [DATA_WIDTH-1:0] rf_write_data;
    logic                  zero_flag;
    logic                  busy;

    modport master (
        output instr_valid, instr_opcode, instr_dst, instr_src, instr_imm, rf_read_data,
        input  instr_ready, rf_read_index, rf_write_index, rf_write_enable, rf_write_data,
               zero_flag, busy
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_dst, instr_src, instr_imm, rf_read_data,
        output instr_ready, rf_read_index, rf_write_index, rf_write_enable, rf_write_data,
               zero_flag, busy
    );
endinterface

// File: rtl/exec_writeback_unit.sv
// Multi-cycle execute stage in front of a 4-entry register file.
// Accepts one instruction per handshake, reads the source register in READ,
// computes a single-cycle ALU result or runs an LSB-first shift-add multiply
// (one multiplier bit per cycle), then writes back for exactly one cycle.
// All outputs come straight from flops; write-port values are loaded on the
// edge that enters WRITE so they are valid for the whole WRITE cycle.
module exec_writeback_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
) (
    input  logic clk,
    input  logic reset,
    exec_writeback_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUBI = 3'd3;
    localparam logic [2:0] OP_ANDI = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_MULI = 3'd6;
    localparam logic [2:0] OP_SHLI = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MUL   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic                  accept_s;

    logic [2:0]            opcode_r;
    logic [IDX_WIDTH-1:0]  dst_r;
    logic [IDX_WIDTH-1:0]  src_r;
    logic [DATA_WIDTH-1:0] imm_r;

    logic [DATA_WIDTH-1:0] mcand_r;
    logic [DATA_WIDTH-1:0] mplier_r;
    logic [DATA_WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] mul_step_s;

    logic                  ready_r;
    logic                  busy_r;
    logic [IDX_WIDTH-1:0]  rd_idx_r;
    logic                  wr_en_r;
    logic [IDX_WIDTH-1:0]  wr_idx_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic                  zero_r;

    // Single-cycle ALU; results wrap modulo 2^DATA_WIDTH, shift uses only the low imm bits.
    function automatic logic [DATA_WIDTH-1:0] alu_result(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] imm
    );
        logic [DATA_WIDTH-1:0] res;
        case (op)
            OP_LDI:  res = imm;
            OP_ADDI: res = a + imm;
            OP_SUBI: res = a - imm;
            OP_ANDI: res = a & imm;
            OP_MOV:  res = a;
            OP_SHLI: res = a << imm[CNT_W-1:0];
            default: res = '0;
        endcase
        return res;
    endfunction

    // ready_r is low in reset and otherwise mirrors "state is IDLE".
    assign accept_s = bus.instr_valid && ready_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                if (opcode_r == OP_NOP) begin
                    next_state_s = IDLE;
                end else if (opcode_r == OP_MULI) begin
                    next_state_s = MUL;
                end else begin
                    next_state_s = WRITE;
                end
            end
            MUL: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = MUL;
                end
            end
            WRITE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Partial product plus the current multiplier bit's contribution.
    always_comb begin
        mul_step_s = acc_r;
        if (mplier_r[0]) begin
            mul_step_s = acc_r + mcand_r;
        end else begin
            mul_step_s = acc_r;
        end
    end

    // Instruction latch, loaded only on an accepted handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_r <= 3'd0;
            dst_r    <= '0;
            src_r    <= '0;
            imm_r    <= '0;
        end else if (accept_s) begin
            opcode_r <= bus.instr_opcode;
            dst_r    <= bus.instr_dst;
            src_r    <= bus.instr_src;
            imm_r    <= bus.instr_imm;
        end
    end

    // Shift-add multiplier: seeded from the operand read in READ, one bit per MUL cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (state_r == READ) begin
            mcand_r  <= bus.rf_read_data;
            mplier_r <= imm_r;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (state_r == MUL) begin
            acc_r    <= mul_step_s;
            mcand_r  <= {mcand_r[DATA_WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[DATA_WIDTH-1:1]};
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Write-port registers: loaded entering WRITE, cleared in every other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_r   <= 1'b0;
            wr_idx_r  <= '0;
            wr_data_r <= '0;
        end else if (next_state_s == WRITE) begin
            wr_en_r  <= 1'b1;
            wr_idx_r <= dst_r;
            if (state_r == MUL) begin
                wr_data_r <= mul_step_s;
            end else begin
                wr_data_r <= alu_result(opcode_r, bus.rf_read_data, imm_r);
            end
        end else begin
            wr_en_r   <= 1'b0;
            wr_idx_r  <= '0;
            wr_data_r <= '0;
        end
    end

    // Handshake, busy and read-index registers, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            rd_idx_r <= '0;
        end else begin
            ready_r <= (next_state_s == IDLE);
            busy_r  <= (next_state_s != IDLE);
            if (accept_s) begin
                rd_idx_r <= bus.instr_src;
            end else begin
                rd_idx_r <= '0;
            end
        end
    end

    // Zero flag follows the value written back; untouched when nothing is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_r <= 1'b0;
        end else if (state_r == WRITE) begin
            zero_r <= (wr_data_r == '0);
        end
    end

    assign bus.instr_ready     = ready_r;
    assign bus.busy            = busy_r;
    assign bus.rf_read_index   = rd_idx_r;
    assign bus.rf_write_enable = wr_en_r;
    assign bus.rf_write_index  = wr_idx_r;
    assign bus.rf_write_data   = wr_data_r;
    assign bus.zero_flag       = zero_r;
endmodule
